// File: rtl/riscv_dmem_bridge.sv
// MEM-stage data port to req/ack bus bridge.
// Stalls the core per access; aligns loads and replicates store lanes.
module riscv_dmem_bridge #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  input  logic          core_rd_en_i,
  input  logic          core_wr_en_i,
  input  logic [2:0]    core_funct3_i,
  output logic [DW-1:0] core_rdata_o,
  output logic          core_stall_o,
  output logic          core_err_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [DW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  output logic [3:0]    bus_be_o,
  input  logic          bus_ack_i,
  input  logic [DW-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;

  logic          req;
  logic          illegal;
  logic [3:0]    be_n;
  logic [DW-1:0] wd_n;
  logic [DW-1:0] shifted;
  logic [DW-1:0] ld_data;
  logic          stall;

  always_comb begin
    req     = core_rd_en_i | core_wr_en_i;
    be_n    = '0;
    wd_n    = core_wdata_i;
    illegal = 1'b0;
    unique case (core_funct3_i[1:0])
      2'b00: begin
        be_n = 4'b0001 << core_addr_i[1:0];
        wd_n = {4{core_wdata_i[7:0]}};
      end
      2'b01: begin
        be_n    = core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_n    = {2{core_wdata_i[15:0]}};
        illegal = core_addr_i[0];
      end
      2'b10: begin
        be_n    = 4'b1111;
        illegal = |core_addr_i[1:0];
      end
      default: illegal = 1'b1;
    endcase
    if (core_rd_en_i & core_wr_en_i) illegal = 1'b1;
  end

  // Raw bus word is aligned using the offset captured at request time.
  always_comb begin
    shifted = bus_rdata_i >> {off_q, 3'b000};
    unique case (f3_q)
      3'b000:  ld_data = {{(DW-8){shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {{(DW-8){1'b0}}, shifted[7:0]};
      3'b001:  ld_data = {{(DW-16){shifted[15]}}, shifted[15:0]};
      3'b101:  ld_data = {{(DW-16){1'b0}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    err_d   = err_q;
    off_d   = off_q;
    f3_d    = f3_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          off_d = core_addr_i[1:0];
          f3_d  = core_funct3_i;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            addr_d  = {core_addr_i[DW-1:2], 2'b00};
            we_d    = core_wr_en_i;
            be_d    = be_n;
            wdata_d = wd_n;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        stall = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (bus_ack_i) begin
          if (!we_q) rdata_d = ld_data;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
    end
  end

  // Reset must release the core at once, even with a request held.
  assign core_stall_o = stall & rst_i;
  assign core_err_o   = (state_q == DONE) & err_q;
  assign core_rdata_o = rdata_q;
  assign bus_req_o    = (state_q == BUS);
  assign bus_we_o     = we_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;
  assign bus_be_o     = be_q;

endmodule

// File: tb/tb_riscv_dmem_bridge.sv
// Bench for riscv_dmem_bridge: directed cases plus random accesses
// against a per-access arithmetic reference model and bus responder.
module tb_riscv_dmem_bridge;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_rd, c_wr, c_stall, c_err;
  logic [2:0]  c_f3;
  logic        b_req, b_we, b_ack;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_rdata = '0;

  riscv_dmem_bridge #(.DW(32), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_addr_i  (c_addr),
    .core_wdata_i (c_wdata),
    .core_rd_en_i (c_rd),
    .core_wr_en_i (c_wr),
    .core_funct3_i(c_f3),
    .core_rdata_o (c_rdata),
    .core_stall_o (c_stall),
    .core_err_o   (c_err),
    .bus_req_o    (b_req),
    .bus_we_o     (b_we),
    .bus_addr_o   (b_addr),
    .bus_wdata_o  (b_wdata),
    .bus_be_o     (b_be),
    .bus_ack_i    (b_ack),
    .bus_rdata_i  (b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c_rd    = 1'b0;
      c_wr    = 1'b0;
      b_ack   = 1'($urandom % 2);
      b_rdata = $urandom;
      #1;
      chk("idle_stall", 32'(c_stall), 0);
      chk("idle_req", 32'(b_req), 0);
      chk("idle_rdata", c_rdata, model_rdata);
    end
  endtask

  task automatic do_access(input logic rd, input logic wr,
                           input logic [2:0] f3,
                           input logic [31:0] addr,
                           input logic [31:0] wd, input int lat,
                           input logic [31:0] bdata);
    int unsigned bytes, off;
    logic        ill, tmo;
    logic [3:0]  ebe;
    logic [31:0] ewd, mask, val;
    int          stalls, reqs, exp_st, exp_rq;
    bit          done;
    bytes = 1 << f3[1:0];
    off   = addr % 4;
    ill   = (f3[1:0] == 2'b11) || (rd && wr) || (addr % bytes != 0);
    tmo   = !ill && (lat >= TO);
    ebe   = 4'(((1 << bytes) - 1) << off);
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % bytes) +: 8];
    val  = bdata >> (8 * off);
    mask = (bytes >= 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * bytes)) - 1;
    val  = val & mask;
    if (!f3[2] && bytes < 4 && val[8*bytes-1]) val = val | ~mask;
    if (!ill) begin
      if (tmo) model_rdata = '0;
      else if (rd) model_rdata = val;
    end
    exp_st = ill ? 1 : (tmo ? 1 + TO : 2 + lat);
    exp_rq = ill ? 0 : (tmo ? TO : lat + 1);

    @(negedge clk);
    c_rd = rd; c_wr = wr; c_f3 = f3; c_addr = addr; c_wdata = wd;
    stalls = 0; reqs = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (b_req) begin
        chk("bus_addr", b_addr, addr & ~32'h3);
        chk("bus_be", 32'(b_be), 32'(ebe));
        chk("bus_we", 32'(b_we), 32'(wr));
        chk("bus_wdata", b_wdata, ewd);
        b_ack   = (reqs == lat);
        b_rdata = b_ack ? bdata : $urandom;
        reqs++;
      end else begin
        b_ack   = 1'($urandom % 2);
        b_rdata = $urandom;
      end
      if (c_stall) begin
        stalls++;
        chk("err_early", 32'(c_err), 0);
        @(negedge clk);
      end else begin
        done = 1;
        chk("done_err", 32'(c_err), 32'(ill || tmo));
        chk("done_rdata", c_rdata, model_rdata);
        chk("stall_cycles", stalls, exp_st);
        chk("req_cycles", reqs, exp_rq);
      end
    end
    if (!done) chk("cycle_bound", 1, 0);
  endtask

  initial begin
    rst = 1'b0; c_rd = 0; c_wr = 0; c_f3 = 0; c_addr = 0; c_wdata = 0;
    b_ack = 0; b_rdata = 0;
    #1;
    chk("rst_req", 32'(b_req), 0);
    chk("rst_we", 32'(b_we), 0);
    chk("rst_addr", b_addr, 0);
    chk("rst_wdata", b_wdata, 0);
    chk("rst_be", 32'(b_be), 0);
    chk("rst_rdata", c_rdata, 0);
    chk("rst_err", 32'(c_err), 0);
    chk("rst_stall", 32'(c_stall), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    do_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    do_access(0, 1, 3'b000, 32'h203, 32'hA5, 3, 32'h0);
    do_access(1, 0, 3'b000, 32'h102, 32'h0, 0, 32'h0080FF00);
    do_access(1, 0, 3'b100, 32'h102, 32'h0, 1, 32'h0080FF00);
    do_access(1, 0, 3'b101, 32'h102, 32'h0, 0, 32'h0080FF00);
    do_access(1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h8001FF00);
    do_access(1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h0);
    do_access(1, 1, 3'b010, 32'h100, 32'h0, 0, 32'h0);
    do_access(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
    do_access(0, 1, 3'b010, 32'h102, 32'h0, 0, 32'h0);
    do_access(0, 1, 3'b001, 32'h302, 32'h1234ABCD, 2, 32'h0);
    do_access(1, 0, 3'b010, 32'h400, 32'h0, 9, 32'h12345678);
    idle(3);
    do_access(1, 0, 3'b010, 32'h404, 32'h0, 0, 32'hCAFEF00D);

    // Reset in the second BUS cycle of a load
    @(negedge clk);
    c_rd = 1; c_wr = 0; c_f3 = 3'b010; c_addr = 32'h500; b_ack = 0;
    @(negedge clk);
    #1 chk("mid_bus1", 32'(b_req), 1);
    @(negedge clk);
    #1 chk("mid_bus2", 32'(b_req), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(b_req), 0);
    chk("mid_rst_stall", 32'(c_stall), 0);
    chk("mid_rst_rdata", c_rdata, 0);
    c_rd = 0;
    model_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    do_access(1, 0, 3'b010, 32'h600, 32'h0, 1, 32'h0BADF00D);

    for (int k = 0; k < 300; k++) begin
      int unsigned kind;
      logic rd, wr;
      logic [2:0] f3;
      logic [31:0] a;
      kind = $urandom % 10;
      rd = (kind == 0) || (kind >= 1 && kind <= 4);
      wr = (kind == 0) || (kind >= 5);
      f3 = 3'($urandom % 8);
      a  = 32'h1000 + ($urandom % 64);
      if ($urandom % 2 == 1) a = a & ~((32'd1 << f3[1:0]) - 1);
      do_access(rd, wr, f3, a, $urandom, int'($urandom % 6), $urandom);
      idle(int'($urandom % 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
